// File: rtl/traffic_ctrl.sv
// Two-direction traffic-light controller: 1 s prescaler, four-phase lamp sequencer, seconds-remaining count.
// Optional night flash mode is compiled in with `define NIGHT_FLASH_EN.
module traffic_ctrl #(
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned GREEN_T  = 30,
    parameter int unsigned YELLOW_T = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hold,
    input  logic       night,
    output logic       ns_r,
    output logic       ns_y,
    output logic       ns_g,
    output logic       ew_r,
    output logic       ew_y,
    output logic       ew_g,
    output logic [7:0] count
);

    localparam logic [2:0] NS_G  = 3'd0;
    localparam logic [2:0] NS_Y  = 3'd1;
    localparam logic [2:0] EW_G  = 3'd2;
    localparam logic [2:0] EW_Y  = 3'd3;
`ifdef NIGHT_FLASH_EN
    localparam logic [2:0] NIGHT = 3'd4;
    localparam logic [15:0] P_HALF = 16'(TICK_DIV / 2);
`endif

    localparam logic [15:0] P_LAST = 16'(TICK_DIV - 1);
    localparam logic [7:0]  G_CNT  = 8'(GREEN_T);
    localparam logic [7:0]  Y_CNT  = 8'(YELLOW_T);

    // Lamp vector order: {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}
    localparam logic [5:0] L_NS_G = 6'b001_100;
    localparam logic [5:0] L_NS_Y = 6'b010_100;
    localparam logic [5:0] L_EW_G = 6'b100_001;
    localparam logic [5:0] L_EW_Y = 6'b100_010;

    logic [2:0]  state, state_nxt;
    logic [7:0]  cnt_nxt;
    logic [15:0] p, p_nxt;
    logic [5:0]  lamps, lamps_nxt;
    logic        p_last;
    logic        sec;

    assign p_last = (p == P_LAST);
    assign sec    = p_last && !hold;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = count;
        p_nxt     = p;
`ifdef NIGHT_FLASH_EN
        if (night) begin
            // Night overrides hold; the blink prescaler free-runs from 0.
            if (state != NIGHT) begin
                state_nxt = NIGHT;
                p_nxt     = '0;
            end else begin
                p_nxt = p_last ? '0 : p + 16'd1;
            end
            cnt_nxt = '0;
        end else if (state == NIGHT) begin
            state_nxt = NS_G;
            cnt_nxt   = G_CNT;
            p_nxt     = '0;
        end else
`endif
        if (!hold) begin
            p_nxt = p_last ? '0 : p + 16'd1;
            if (sec) begin
                if (count > 8'd1) begin
                    cnt_nxt = count - 8'd1;
                end else begin
                    case (state)
                        NS_G: begin
                            state_nxt = NS_Y;
                            cnt_nxt   = Y_CNT;
                        end
                        NS_Y: begin
                            state_nxt = EW_G;
                            cnt_nxt   = G_CNT;
                        end
                        EW_G: begin
                            state_nxt = EW_Y;
                            cnt_nxt   = Y_CNT;
                        end
                        default: begin
                            state_nxt = NS_G;
                            cnt_nxt   = G_CNT;
                        end
                    endcase
                end
            end
        end
    end

    // Lamps are decoded from next-state values so the registered outputs change on the same edge as state.
    always_comb begin
        lamps_nxt = L_NS_G;
        case (state_nxt)
            NS_G:    lamps_nxt = L_NS_G;
            NS_Y:    lamps_nxt = L_NS_Y;
            EW_G:    lamps_nxt = L_EW_G;
            EW_Y:    lamps_nxt = L_EW_Y;
`ifdef NIGHT_FLASH_EN
            NIGHT:   lamps_nxt = (p_nxt < P_HALF) ? 6'b010_010 : 6'b000_000;
`endif
            default: lamps_nxt = L_NS_G;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= NS_G;
            count <= G_CNT;
            p     <= '0;
            lamps <= L_NS_G;
        end else begin
            state <= state_nxt;
            count <= cnt_nxt;
            p     <= p_nxt;
            lamps <= lamps_nxt;
        end
    end

    assign {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g} = lamps;

`ifndef NIGHT_FLASH_EN
    logic night_unused;
    assign night_unused = night;
`endif

endmodule

// File: tb/tb_traffic_ctrl.sv
// Directed self-checking bench for traffic_ctrl with TICK_DIV=4, GREEN_T=5, YELLOW_T=2.
module tb_traffic_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hold = 1'b0;
    logic       night = 1'b0;
    logic       ns_r, ns_y, ns_g, ew_r, ew_y, ew_g;
    logic [7:0] count;
    logic [5:0] lamps;

    int errors = 0;
    int checks = 0;

    traffic_ctrl #(
        .TICK_DIV(4),
        .GREEN_T (5),
        .YELLOW_T(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hold (hold),
        .night(night),
        .ns_r (ns_r),
        .ns_y (ns_y),
        .ns_g (ns_g),
        .ew_r (ew_r),
        .ew_y (ew_y),
        .ew_g (ew_g),
        .count(count)
    );

    always #5 clk = ~clk;

    assign lamps = {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g};

    // Expected values after k rising edges since reset release (4 edges per second, 14-second cycle).
    function automatic logic [7:0] exp_cnt(input int k);
        int tab [14] = '{5, 4, 3, 2, 1, 2, 1, 5, 4, 3, 2, 1, 2, 1};
        return 8'(tab[(k / 4) % 14]);
    endfunction

    function automatic logic [5:0] exp_lmp(input int k);
        int idx;
        idx = (k / 4) % 14;
        if (idx < 5)       return 6'b001_100;
        else if (idx < 7)  return 6'b010_100;
        else if (idx < 12) return 6'b100_001;
        else               return 6'b100_010;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hold  = 1'b0;
        night = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (31) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (lamps !== 6'b001_100) begin
            errors++;
            $display("FAIL reset_lamps: lamps=%b expected %b", lamps, 6'b001_100);
        end
        checks++;
        if (count !== 8'd5) begin
            errors++;
            $display("FAIL reset_count: count=%0d expected 5", count);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (count !== ((k < 4) ? 8'd5 : 8'd4)) begin
                errors++;
                $display("FAIL reset_first_dec: edge %0d count=%0d expected %0d", k, count, (k < 4) ? 5 : 4);
            end
        end
    endtask

    task automatic test_full_cycle();
        do_reset();
        for (int k = 0; k <= 60; k++) begin
            if (k > 0) step();
            checks++;
            if (count !== exp_cnt(k) || lamps !== exp_lmp(k)) begin
                errors++;
                $display("FAIL full_cycle: edge %0d count=%0d lamps=%b expected count=%0d lamps=%b",
                         k, count, lamps, exp_cnt(k), exp_lmp(k));
            end
        end
    endtask

    task automatic test_phase_boundary();
        do_reset();
        repeat (19) step();
        checks++;
        if (count !== 8'd1 || lamps !== 6'b001_100) begin
            errors++;
            $display("FAIL boundary_pre: count=%0d lamps=%b expected count=1 lamps=001100", count, lamps);
        end
        step();
        checks++;
        if (count !== 8'd2 || lamps !== 6'b010_100) begin
            errors++;
            $display("FAIL boundary_post: count=%0d lamps=%b expected count=2 lamps=010100", count, lamps);
        end
    endtask

    task automatic test_hold();
        do_reset();
        repeat (9) step();
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (count !== 8'd3 || lamps !== 6'b001_100) begin
                errors++;
                $display("FAIL hold_frozen: cycle %0d count=%0d lamps=%b expected count=3 lamps=001100",
                         i, count, lamps);
            end
        end
        hold = 1'b0;
        for (int k = 20; k <= 40; k++) begin
            step();
            checks++;
            if (count !== exp_cnt(k - 10) || lamps !== exp_lmp(k - 10)) begin
                errors++;
                $display("FAIL hold_resume: edge %0d count=%0d lamps=%b expected count=%0d lamps=%b",
                         k, count, lamps, exp_cnt(k - 10), exp_lmp(k - 10));
            end
        end
    endtask

`ifdef NIGHT_FLASH_EN
    task automatic test_night();
        logic [5:0] ey;
        do_reset();
        repeat (33) step();
        night = 1'b1;
        for (int j = 0; j < 10; j++) begin
            step();
            ey = ((j % 4) < 2) ? 6'b010_010 : 6'b000_000;
            checks++;
            if (count !== 8'd0 || lamps !== ey) begin
                errors++;
                $display("FAIL night_blink: cycle %0d count=%0d lamps=%b expected count=0 lamps=%b",
                         j, count, lamps, ey);
            end
            if (j == 2) hold = 1'b1;
        end
        night = 1'b0;
        hold  = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            step();
            checks++;
            if (count !== exp_cnt(k) || lamps !== exp_lmp(k)) begin
                errors++;
                $display("FAIL night_exit: edge %0d count=%0d lamps=%b expected count=%0d lamps=%b",
                         k, count, lamps, exp_cnt(k), exp_lmp(k));
            end
        end
    endtask
`else
    task automatic test_night();
        do_reset();
        repeat (33) step();
        night = 1'b1;
        for (int k = 34; k <= 90; k++) begin
            step();
            checks++;
            if (count !== exp_cnt(k) || lamps !== exp_lmp(k)) begin
                errors++;
                $display("FAIL night_ignored: edge %0d count=%0d lamps=%b expected count=%0d lamps=%b",
                         k, count, lamps, exp_cnt(k), exp_lmp(k));
            end
        end
        night = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_full_cycle();
        test_phase_boundary();
        test_hold();
        test_night();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
